// File: rtl/controle_escrita_registradores_pkg.sv
// -----------------------------------------------------------------------------
// controle_escrita_registradores_pkg
// Shared definitions for the register-file write-port controller:
//   - data and register-index widths, register count
//   - index of the hard-wired zero register
//   - writeback source identifiers (also the bit positions in the request and
//     grant vectors of the arbiter)
//   - helper that turns a register index into a one-hot scoreboard mask
// -----------------------------------------------------------------------------
package controle_escrita_registradores_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = {ADDR_WIDTH{1'b0}};

    // Source IDs double as bit positions in the arbiter's req/gnt vectors.
    typedef enum logic {
        SRC_ULA = 1'b0,
        SRC_MEM = 1'b1
    } fonte_t;

    // One-hot mask with only bit idx set.
    function automatic logic [NUM_REGS-1:0] mascara_reg(input logic [ADDR_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] um;
        um = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return um << idx;
    endfunction

endpackage

// File: rtl/controle_escrita_registradores_if.sv
// -----------------------------------------------------------------------------
// controle_escrita_registradores_if
// Bundles every signal between the write-port controller and its neighbours:
//   ULA writeback   : ula_valid, ula_rd, ula_dado       -> ula_ready
//   Load writeback  : mem_valid, mem_rd, mem_dado       -> mem_ready
//   Decode reserve  : reserva_valid, reserva_rd         -> reserva_ready
//   Decode hazard   : rs, rt                            -> stall
//   Register file   : RegWrite, rd, dado_escrita (write port), pendentes
// Modports:
//   master - the surrounding pipeline (requesters, decode, banco side)
//   slave  - the controller itself
// -----------------------------------------------------------------------------
interface controle_escrita_registradores_if
    import controle_escrita_registradores_pkg::*;
();

    logic                  ula_valid;
    logic [ADDR_WIDTH-1:0] ula_rd;
    logic [DATA_WIDTH-1:0] ula_dado;
    logic                  ula_ready;

    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] mem_dado;
    logic                  mem_ready;

    logic                  reserva_valid;
    logic [ADDR_WIDTH-1:0] reserva_rd;
    logic                  reserva_ready;

    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic                  stall;

    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] dado_escrita;
    logic [NUM_REGS-1:0]   pendentes;

    modport master (
        output ula_valid, ula_rd, ula_dado,
        input  ula_ready,
        output mem_valid, mem_rd, mem_dado,
        input  mem_ready,
        output reserva_valid, reserva_rd,
        input  reserva_ready,
        output rs, rt,
        input  stall,
        input  RegWrite, rd, dado_escrita, pendentes
    );

    modport slave (
        input  ula_valid, ula_rd, ula_dado,
        output ula_ready,
        input  mem_valid, mem_rd, mem_dado,
        output mem_ready,
        input  reserva_valid, reserva_rd,
        output reserva_ready,
        input  rs, rt,
        output stall,
        output RegWrite, rd, dado_escrita, pendentes
    );

endinterface

// File: rtl/arbitro_rr2.sv
// -----------------------------------------------------------------------------
// arbitro_rr2
// Two-way round-robin arbiter. A grant is the acceptance itself (the
// requester holds its request until granted), so the pointer advances on
// every grant.
// Ports:
//   clock    in   clock, state on posedge
//   reset_n  in   asynchronous active-low reset; also masks all grants
//   i_req    in   [1:0] requests, bit index = source ID
//   o_gnt    out  [1:0] one-hot (or zero) grant, combinational
// On a tie the source NOT granted most recently wins. After reset the
// pointer says "ULA last", so MEM wins the first tie.
// -----------------------------------------------------------------------------
module arbitro_rr2
    import controle_escrita_registradores_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    fonte_t     r_ultimo;
    logic [1:0] w_req_ativo;
    logic [1:0] w_gnt;

    // Grant decode; requests are masked while reset is asserted so no
    // handshake completes during reset.
    always_comb begin
        w_req_ativo = i_req & {2{reset_n}};
        w_gnt       = 2'b00;
        case (w_req_ativo)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11: begin
                if (r_ultimo == SRC_ULA) begin
                    w_gnt = 2'b10;
                end else begin
                    w_gnt = 2'b01;
                end
            end
            default: w_gnt = 2'b00;
        endcase
    end

    // Last-granted pointer, updated only when a grant is issued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ultimo <= SRC_ULA;
        end else if (w_gnt[SRC_MEM]) begin
            r_ultimo <= SRC_MEM;
        end else if (w_gnt[SRC_ULA]) begin
            r_ultimo <= SRC_ULA;
        end else begin
            r_ultimo <= r_ultimo;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/controle_escrita_registradores.sv
// -----------------------------------------------------------------------------
// controle_escrita_registradores
// Write-port controller for banco_registradores.
//   - Arbitrates the single write port between the ULA and load writeback
//     sources (round-robin, see arbitro_rr2).
//   - Registers the winning write onto RegWrite / rd / dado_escrita; the
//     register file commits it on the following edge.
//   - Keeps a per-register pending scoreboard: decode reserves a
//     destination, the bit clears on the edge the write is presented to the
//     register file, and stall is raised while rs/rt are pending.
// Ports:
//   clock    in   single clock, all state on posedge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of controle_escrita_registradores_if
//            (ula_*/mem_* writeback handshakes, reserva_* reservation,
//             rs/rt/stall hazard check, RegWrite/rd/dado_escrita/pendentes)
// ready/stall outputs are combinational; write port and scoreboard are
// registered. Register 0 is never written and never marked pending.
// -----------------------------------------------------------------------------
module controle_escrita_registradores
    import controle_escrita_registradores_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset_n,
    controle_escrita_registradores_if.slave bus
);

    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_dado;
    logic                  w_aceita;
    logic                  w_escreve;
    logic                  w_limpa;
    logic                  w_marca;
    logic                  w_reserva_ready;
    logic                  w_stall;
    logic [NUM_REGS-1:0]   w_mask_limpa;
    logic [NUM_REGS-1:0]   w_mask_marca;
    logic [NUM_REGS-1:0]   w_pend_nxt;

    logic                  r_regwrite;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_dado;
    logic [NUM_REGS-1:0]   r_pendentes;

    // Request vector ordered by source ID: bit 0 = ULA, bit 1 = MEM.
    assign w_req = {bus.mem_valid, bus.ula_valid};

    arbitro_rr2 u_arbitro (
        .clock   (clock),
        .reset_n (reset_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    assign bus.ula_ready = w_gnt[SRC_ULA];
    assign bus.mem_ready = w_gnt[SRC_MEM];

    // Mux of the granted source; a writeback to r0 is accepted but dropped.
    always_comb begin
        w_sel_rd   = bus.ula_rd;
        w_sel_dado = bus.ula_dado;
        if (w_gnt[SRC_MEM]) begin
            w_sel_rd   = bus.mem_rd;
            w_sel_dado = bus.mem_dado;
        end else begin
            w_sel_rd   = bus.ula_rd;
            w_sel_dado = bus.ula_dado;
        end
        w_aceita  = |w_gnt;
        w_escreve = w_aceita && (w_sel_rd != REG_ZERO);
    end

    // Registered write port; rd/dado keep their last value when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_regwrite <= 1'b0;
            r_rd       <= REG_ZERO;
            r_dado     <= {DATA_WIDTH{1'b0}};
        end else if (w_escreve) begin
            r_regwrite <= 1'b1;
            r_rd       <= w_sel_rd;
            r_dado     <= w_sel_dado;
        end else begin
            r_regwrite <= 1'b0;
            r_rd       <= r_rd;
            r_dado     <= r_dado;
        end
    end

    // Reservation / hazard decode. A reservation of an already pending
    // register (WAW) is refused; r0 is always accepted and never marked.
    always_comb begin
        w_reserva_ready = (!r_pendentes[bus.reserva_rd]) || (bus.reserva_rd == REG_ZERO);
        w_marca         = bus.reserva_valid && w_reserva_ready && (bus.reserva_rd != REG_ZERO);
        w_stall         = ((bus.rs != REG_ZERO) && r_pendentes[bus.rs]) ||
                          ((bus.rt != REG_ZERO) && r_pendentes[bus.rt]);
    end

    // Scoreboard next state: the bit clears on the edge the register file
    // commits (write currently presented). Set is applied after clear so a
    // new producer reserving the same register on that edge keeps it pending.
    always_comb begin
        w_limpa      = r_regwrite && (r_rd != REG_ZERO);
        w_mask_limpa = w_limpa ? mascara_reg(r_rd) : {NUM_REGS{1'b0}};
        w_mask_marca = w_marca ? mascara_reg(bus.reserva_rd) : {NUM_REGS{1'b0}};
        w_pend_nxt   = (r_pendentes & ~w_mask_limpa) | w_mask_marca;
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pendentes <= {NUM_REGS{1'b0}};
        end else begin
            r_pendentes <= w_pend_nxt;
        end
    end

    assign bus.reserva_ready = w_reserva_ready;
    assign bus.stall         = w_stall;
    assign bus.RegWrite      = r_regwrite;
    assign bus.rd            = r_rd;
    assign bus.dado_escrita  = r_dado;
    assign bus.pendentes     = r_pendentes;

endmodule

// File: tb/tb_controle_escrita_registradores.sv
// -----------------------------------------------------------------------------
// tb_controle_escrita_registradores
// Directed scenarios followed by randomized traffic. A reference model
// (pending flags per register, last-granted source, pending write, and a
// register-file image) predicts every combinational and registered output.
// Inputs are driven on the falling edge; combinational outputs are sampled
// 1 time unit later and registered outputs 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_controle_escrita_registradores;
    import controle_escrita_registradores_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    controle_escrita_registradores_if bus ();

    controle_escrita_registradores dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_comp  = 0;
    int n_falha = 0;

    // Reference model state
    bit                    m_pend [NUM_REGS];
    int                    m_ultimo;        // 0: ULA granted last, 1: MEM granted last
    bit                    m_we;
    logic [ADDR_WIDTH-1:0] m_rd;
    logic [DATA_WIDTH-1:0] m_dado;
    logic [DATA_WIDTH-1:0] banco_ref [NUM_REGS];
    logic [DATA_WIDTH-1:0] banco_dut [NUM_REGS];
    bit                    ula_aceito;
    bit                    mem_aceito;
    int                    n_ula;
    int                    n_mem;
    bit                    g_ula;
    bit                    g_mem;

    task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_falha++;
            $display("FAIL %s: obtido=0x%0h esperado=0x%0h", tag, obs, esp);
        end
    endtask

    function automatic logic [NUM_REGS-1:0] pend_vec();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic reset_modelo();
        for (int i = 0; i < NUM_REGS; i++) m_pend[i] = 1'b0;
        m_ultimo = 0;
        m_we     = 1'b0;
        m_rd     = '0;
        m_dado   = '0;
    endtask

    task automatic zera_entradas();
        bus.ula_valid     = 1'b0; bus.ula_rd = '0; bus.ula_dado = '0;
        bus.mem_valid     = 1'b0; bus.mem_rd = '0; bus.mem_dado = '0;
        bus.reserva_valid = 1'b0; bus.reserva_rd = '0;
        bus.rs            = '0;   bus.rt = '0;
    endtask

    // One clock cycle: called just after a falling edge with inputs set;
    // returns at the next falling edge.
    task automatic passo();
        bit                    e_ula, e_mem, e_res, e_stall, acc;
        logic [ADDR_WIDTH-1:0] s_rd;
        logic [DATA_WIDTH-1:0] s_dado;
        #1;
        e_ula   = bus.ula_valid && (!bus.mem_valid || m_ultimo == 1);
        e_mem   = bus.mem_valid && (!bus.ula_valid || m_ultimo == 0);
        e_res   = (bus.reserva_rd == 0) || !m_pend[bus.reserva_rd];
        e_stall = (bus.rs != 0 && m_pend[bus.rs]) || (bus.rt != 0 && m_pend[bus.rt]);
        checa("ula_ready", 32'(bus.ula_ready), 32'(e_ula));
        checa("mem_ready", 32'(bus.mem_ready), 32'(e_mem));
        checa("reserva_ready", 32'(bus.reserva_ready), 32'(e_res));
        checa("stall", 32'(bus.stall), 32'(e_stall));
        acc = 1'b0; s_rd = '0; s_dado = '0;
        if (e_ula) begin acc = 1'b1; m_ultimo = 0; s_rd = bus.ula_rd; s_dado = bus.ula_dado; end
        if (e_mem) begin acc = 1'b1; m_ultimo = 1; s_rd = bus.mem_rd; s_dado = bus.mem_dado; end
        // register file commits the presented write on this edge
        if (m_we) begin banco_ref[m_rd] = m_dado; m_pend[m_rd] = 1'b0; end
        if (bus.reserva_valid && e_res && bus.reserva_rd != 0) m_pend[bus.reserva_rd] = 1'b1;
        m_we = acc && (s_rd != 0);
        if (m_we) begin m_rd = s_rd; m_dado = s_dado; end
        ula_aceito = e_ula;
        mem_aceito = e_mem;
        if (bus.RegWrite === 1'b1) banco_dut[bus.rd] = bus.dado_escrita;
        @(posedge clock);
        #1;
        checa("RegWrite", 32'(bus.RegWrite), 32'(m_we));
        checa("rd", 32'(bus.rd), 32'(m_rd));
        checa("dado_escrita", bus.dado_escrita, m_dado);
        checa("pendentes", bus.pendentes, pend_vec());
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        zera_entradas();
        for (int i = 0; i < NUM_REGS; i++) begin banco_ref[i] = '0; banco_dut[i] = '0; end
        reset_modelo();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checa("rst_regwrite", 32'(bus.RegWrite), 32'd0);
        checa("rst_pendentes", bus.pendentes, 32'd0);
        reset_n = 1'b1;

        // 1: reset mid-cycle with both sources valid and state non-zero
        bus.reserva_valid = 1'b1; bus.reserva_rd = 5'd4;
        bus.ula_valid = 1'b1; bus.ula_rd = 5'd9; bus.ula_dado = 32'h99;
        passo();
        checa("t1_regwrite_antes", 32'(bus.RegWrite), 32'd1);
        bus.reserva_valid = 1'b0;
        bus.ula_valid = 1'b1; bus.ula_rd = 5'd11; bus.ula_dado = 32'hBB;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_dado = 32'hAA;
        #2 reset_n = 1'b0;
        #1;
        checa("t1_ula_ready_rst", 32'(bus.ula_ready), 32'd0);
        checa("t1_mem_ready_rst", 32'(bus.mem_ready), 32'd0);
        checa("t1_regwrite_rst", 32'(bus.RegWrite), 32'd0);
        checa("t1_pendentes_rst", bus.pendentes, 32'd0);
        reset_modelo();
        @(negedge clock);
        reset_n = 1'b1;
        passo();
        checa("t1_mem_ganha_1o_empate", 32'(bus.rd), 32'd10);
        bus.mem_valid = 1'b0;
        passo();
        checa("t1_ula_depois", 32'(bus.rd), 32'd11);
        bus.ula_valid = 1'b0;
        passo();

        // 2: single write to a reserved register
        bus.reserva_valid = 1'b1; bus.reserva_rd = 5'd4;
        passo();
        bus.reserva_valid = 1'b0;
        bus.ula_valid = 1'b1; bus.ula_rd = 5'd4; bus.ula_dado = 32'd8; bus.rs = 5'd4;
        #1;
        checa("t2_ula_ready", 32'(bus.ula_ready), 32'd1);
        checa("t2_stall", 32'(bus.stall), 32'd1);
        passo();
        checa("t2_regwrite", 32'(bus.RegWrite), 32'd1);
        checa("t2_rd", 32'(bus.rd), 32'd4);
        checa("t2_dado", bus.dado_escrita, 32'd8);
        checa("t2_pend4_ainda", 32'(bus.pendentes[4]), 32'd1);
        bus.ula_valid = 1'b0;
        passo();
        checa("t2_pend4_limpo", 32'(bus.pendentes[4]), 32'd0);
        checa("t2_banco_r4", banco_dut[4], 32'd8);
        #1;
        checa("t2_stall_fim", 32'(bus.stall), 32'd0);
        bus.rs = 5'd0;

        // 3: contention, each source accepted once, alternating grants
        bus.ula_valid = 1'b1; bus.ula_rd = 5'd5; bus.ula_dado = 32'hF;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd6; bus.mem_dado = 32'hA;
        n_ula = 0; n_mem = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            g_ula = bus.ula_ready;
            g_mem = bus.mem_ready;
            passo();
            if (g_ula) begin n_ula++; bus.ula_valid = 1'b0; end
            if (g_mem) begin n_mem++; bus.mem_valid = 1'b0; end
            if (c == 0) checa("t3_1a_escrita_rd", 32'(bus.rd), 32'd6);
            if (c == 1) checa("t3_2a_escrita_rd", 32'(bus.rd), 32'd5);
        end
        checa("t3_ula_aceites", 32'(n_ula), 32'd1);
        checa("t3_mem_aceites", 32'(n_mem), 32'd1);

        // 4: hazard on rs, r0 never stalls
        bus.reserva_valid = 1'b1; bus.reserva_rd = 5'd4;
        passo();
        bus.reserva_valid = 1'b0; bus.rs = 5'd4;
        repeat (2) passo();
        #1;
        checa("t4_stall_rs4", 32'(bus.stall), 32'd1);
        bus.rs = 5'd0; bus.rt = 5'd0;
        #1;
        checa("t4_stall_rs0", 32'(bus.stall), 32'd0);
        bus.ula_valid = 1'b1; bus.ula_rd = 5'd4; bus.ula_dado = 32'h44;
        passo();
        bus.ula_valid = 1'b0;
        passo();
        bus.rs = 5'd4;
        #1;
        checa("t4_stall_limpo", 32'(bus.stall), 32'd0);
        bus.rs = 5'd0;

        // 5: WAW refusal and r0 writeback
        bus.reserva_valid = 1'b1; bus.reserva_rd = 5'd7;
        passo();
        #1;
        checa("t5_reserva_waw", 32'(bus.reserva_ready), 32'd0);
        passo();
        bus.reserva_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_dado = 32'h55;
        #1;
        checa("t5_mem_ready_r0", 32'(bus.mem_ready), 32'd1);
        passo();
        checa("t5_regwrite_r0", 32'(bus.RegWrite), 32'd0);
        bus.mem_valid = 1'b0;

        // 6: clear and new reservation of r3 on the same edge
        bus.ula_valid = 1'b1; bus.ula_rd = 5'd3; bus.ula_dado = 32'h33;
        passo();
        bus.ula_valid = 1'b0;
        bus.reserva_valid = 1'b1; bus.reserva_rd = 5'd3;
        checa("t6_regwrite_r3", 32'(bus.RegWrite), 32'd1);
        passo();
        checa("t6_pend3_set_vence", 32'(bus.pendentes[3]), 32'd1);
        bus.reserva_valid = 1'b0;

        // Randomized traffic on a small register window to force collisions
        ula_aceito = 1'b0;
        mem_aceito = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!bus.ula_valid || ula_aceito) begin
                bus.ula_valid = 1'($urandom_range(0, 1));
                bus.ula_rd    = 5'($urandom_range(0, 7));
                bus.ula_dado  = $urandom;
            end
            if (!bus.mem_valid || mem_aceito) begin
                bus.mem_valid = 1'($urandom_range(0, 1));
                bus.mem_rd    = 5'($urandom_range(0, 7));
                bus.mem_dado  = $urandom;
            end
            bus.reserva_valid = ($urandom_range(0, 2) == 0);
            bus.reserva_rd    = 5'($urandom_range(0, 7));
            bus.rs            = 5'($urandom_range(0, 7));
            bus.rt            = 5'($urandom_range(0, 7));
            passo();
        end
        zera_entradas();
        repeat (2) passo();

        for (int i = 0; i < NUM_REGS; i++) checa($sformatf("banco_r%0d", i), banco_dut[i], banco_ref[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
        $finish;
    end

endmodule
